// File: rtl/seq_pkg.sv
// ============================================================================
// Module      : seq_pkg
// Description : Shared definitions for the serial frame generator.
//               Holds the generator state enum and the completed-frame
//               counter type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    // Width of the completed-frame counter
    localparam int c_FRAME_CNT_W = 16;

    // Generator state. GUARD is only reachable when the guard gap is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } state_t;

    typedef logic [c_FRAME_CNT_W-1:0] frame_cnt_t;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_gen_if.sv
// ============================================================================
// Module      : seq_gen_if
// Description : Frame-request and serial-output bundle for seq_gen.
//               master : frame requester / bit-stream observer
//               slave  : the generator
//   in_valid  (m->s)  frame request valid
//   in_ready  (s->m)  generator can accept a frame
//   in_data   (m->s)  frame bits, bit len-1 sent first
//   in_len    (m->s)  number of bits to send (0..WIDTH, larger is clamped)
//   d         (s->m)  serial data bit
//   d_valid   (s->m)  d carries a driven bit this cycle
//   done      (s->m)  pulse on the last data bit of a frame
//   frame_cnt (s->m)  completed non-empty frame count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_gen_if
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    localparam int LW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic             d;
    logic             d_valid;
    logic             done;
    frame_cnt_t       frame_cnt;

    modport master (
        output in_valid,
        output in_data,
        output in_len,
        input  in_ready,
        input  d,
        input  d_valid,
        input  done,
        input  frame_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_len,
        output in_ready,
        output d,
        output d_valid,
        output done,
        output frame_cnt
    );

endinterface : seq_gen_if

`default_nettype wire

// File: rtl/seq_gen.sv
// ============================================================================
// Module      : seq_gen
// Description : Serial frame generator. Accepts a frame (data + length) on a
//               valid/ready handshake and shifts the bits out MSB-of-frame
//               first, one per clock, on d/d_valid. done pulses with the last
//               bit and frame_cnt counts completed non-empty frames.
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   bus       seq_gen_if.slave (handshake, serial output, frame count)
// Config      : define SEQ_GEN_GUARD_EN to append GUARD_BITS zero bits
//               (d=0, d_valid=1) after every non-empty frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GUARD_BITS = 3
) (
    input  wire logic clk,
    input  wire logic reset,
    seq_gen_if.slave  bus
);

    localparam int            LW          = $clog2(WIDTH) + 1;
    localparam logic [LW-1:0] c_WIDTH_LEN = LW'(WIDTH);
    localparam logic [LW-1:0] c_ONE       = LW'(1);

    // Elaboration-time range checks on the parameters
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_gen: WIDTH must be in 2..32");
    end
    if (GUARD_BITS < 1 || GUARD_BITS > 15) begin : g_bad_guard
        $error("seq_gen: GUARD_BITS must be in 1..15");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [LW-1:0]    r_bit_cnt;
    frame_cnt_t       r_frame_cnt;
    logic [LW-1:0]    w_len;
    logic [LW-1:0]    w_shamt;
    logic             w_accept;
    logic             w_last_bit;

    // Oversized requests are clamped to the register width
    assign w_len      = (bus.in_len > c_WIDTH_LEN) ? c_WIDTH_LEN : bus.in_len;
    // Left-justify the frame so the first bit to send sits in the MSB
    assign w_shamt    = c_WIDTH_LEN - w_len;
    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_last_bit = (r_state == SEND) && (r_bit_cnt == c_ONE);

`ifdef SEQ_GEN_GUARD_EN
    localparam int            GW           = $clog2(GUARD_BITS + 1);
    localparam logic [GW-1:0] c_GUARD_LOAD = GW'(GUARD_BITS);

    logic [GW-1:0] r_guard_cnt;
    logic          w_guard_last;

    assign w_guard_last = (r_state == GUARD) && (r_guard_cnt == GW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_guard_cnt <= '0;
        end else if (w_last_bit) begin
            r_guard_cnt <= c_GUARD_LOAD;
        end else if (r_state == GUARD) begin
            r_guard_cnt <= r_guard_cnt - GW'(1);
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and outputs; d is forced low whenever d_valid is low
    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = 1'b0;
        bus.d        = 1'b0;
        bus.d_valid  = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                // A zero-length request is consumed without leaving IDLE
                if (w_accept && (w_len != '0)) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                bus.d       = r_shift[WIDTH-1];
                bus.d_valid = 1'b1;
                bus.done    = w_last_bit;
                if (w_last_bit) begin
`ifdef SEQ_GEN_GUARD_EN
                    w_state_nxt = GUARD;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef SEQ_GEN_GUARD_EN
            GUARD: begin
                bus.d_valid = 1'b1;
                if (w_guard_last) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: shift register, remaining-bit counter, frame counter.
    // Inputs are only sampled on the accept cycle, so later changes on the
    // request side cannot disturb a frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= bus.in_data << w_shamt;
            r_bit_cnt <= w_len;
        end else if (r_state == SEND) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - c_ONE;
            if (w_last_bit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign bus.frame_cnt = r_frame_cnt;

endmodule : seq_gen

`default_nettype wire

// File: tb/tb_seq_gen.sv
// ============================================================================
// Module      : tb_seq_gen
// Description : Directed self-checking bench for seq_gen (WIDTH=8,
//               GUARD_BITS=3). Expected bit streams, timing and counts are
//               computed here from the frame parameters. Build with
//               SEQ_GEN_GUARD_EN defined to exercise the guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_gen;
    import seq_pkg::*;

    localparam int WIDTH      = 8;
    localparam int GUARD_BITS = 3;
`ifdef SEQ_GEN_GUARD_EN
    localparam int G = GUARD_BITS;
`else
    localparam int G = 0;
`endif

    logic clk;
    logic reset;

    seq_gen_if #(.WIDTH(WIDTH)) bus ();

    seq_gen #(
        .WIDTH      (WIDTH),
        .GUARD_BITS (GUARD_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    frame_cnt_t exp_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame, then check every cycle up to the return to IDLE
    task automatic run_frame(input logic [7:0] data, input logic [3:0] len, input string tag);
        int n;
        n = (len > 4'd8) ? 8 : int'(len);
        bus.in_data  = data;
        bus.in_len   = len;
        bus.in_valid = 1'b1;
        check({tag, "_rdy_T"}, 32'(bus.in_ready), 32'd1);
        tick();
        // Request-side changes after the handshake must not matter
        bus.in_valid = 1'b0;
        bus.in_data  = ~data;
        bus.in_len   = 4'd2;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_dv%0d", tag, i),   32'(bus.d_valid),  32'd1);
            check($sformatf("%s_d%0d", tag, i),    32'(bus.d),        32'(data[n-1-i]));
            check($sformatf("%s_done%0d", tag, i), 32'(bus.done),     32'(i == n-1));
            check($sformatf("%s_rdy%0d", tag, i),  32'(bus.in_ready), 32'd0);
            check($sformatf("%s_cnt%0d", tag, i),  32'(bus.frame_cnt), 32'(exp_cnt));
            tick();
        end
        if (n > 0) exp_cnt = exp_cnt + 16'd1;
        if (n > 0) begin
            for (int g = 0; g < G; g++) begin
                check($sformatf("%s_gdv%0d", tag, g), 32'(bus.d_valid), 32'd1);
                check($sformatf("%s_gd%0d", tag, g),  32'(bus.d),       32'd0);
                check($sformatf("%s_grdy%0d", tag, g), 32'(bus.in_ready), 32'd0);
                tick();
            end
        end
        check({tag, "_rdy_end"}, 32'(bus.in_ready),  32'd1);
        check({tag, "_dv_end"},  32'(bus.d_valid),   32'd0);
        check({tag, "_d_end"},   32'(bus.d),         32'd0);
        check({tag, "_done_end"}, 32'(bus.done),     32'd0);
        check({tag, "_cnt_end"}, 32'(bus.frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] a_dat;
        logic [7:0] b_dat;
        logic       e_dv;
        logic       e_d;
        logic       e_rdy;
        logic       e_done;
        int         j;

        n_checks     = 0;
        n_fail       = 0;
        exp_cnt      = '0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(bus.in_ready),  32'd1);
        check("rst_dv",  32'(bus.d_valid),   32'd0);
        check("rst_d",   32'(bus.d),         32'd0);
        check("rst_done", 32'(bus.done),     32'd0);
        check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic frame: 101
        run_frame(8'b0000_0101, 4'd3, "f101");
        // Zero-length request: consumed, nothing emitted
        run_frame(8'hFF, 4'd0, "len0");
        // Full width and clamped length
        run_frame(8'b1100_1010, 4'd8, "full");
        run_frame(8'b1010_0101, 4'd12, "clamp");
        run_frame(8'b0000_0001, 4'd1, "one");

        // Back-to-back with in_valid held high
        a_dat = 8'b0000_1001;
        b_dat = 8'b0000_0110;
        bus.in_data  = a_dat;
        bus.in_len   = 4'd4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = b_dat;
        for (int i = 1; i <= 10 + 2*G; i++) begin
            if (i == 6 + G) bus.in_valid = 1'b0;
            if (i == 5 || i == 10 + G) exp_cnt = exp_cnt + 16'd1;
            e_dv = 1'b0; e_d = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
            if (i <= 4) begin
                e_dv = 1'b1; e_d = a_dat[4-i]; e_done = (i == 4);
            end else if (i <= 4 + G) begin
                e_dv = 1'b1;
            end else if (i == 5 + G) begin
                e_rdy = 1'b1;
            end else if (i <= 9 + G) begin
                j = i - (5 + G);
                e_dv = 1'b1; e_d = b_dat[4-j]; e_done = (j == 4);
            end else if (i <= 9 + 2*G) begin
                e_dv = 1'b1;
            end else begin
                e_rdy = 1'b1;
            end
            check($sformatf("b2b_dv%0d", i),   32'(bus.d_valid),   32'(e_dv));
            check($sformatf("b2b_d%0d", i),    32'(bus.d),         32'(e_d));
            check($sformatf("b2b_rdy%0d", i),  32'(bus.in_ready),  32'(e_rdy));
            check($sformatf("b2b_done%0d", i), 32'(bus.done),      32'(e_done));
            check($sformatf("b2b_cnt%0d", i),  32'(bus.frame_cnt), 32'(exp_cnt));
            tick();
        end

        // Reset in the middle of a len=8 frame
        bus.in_data  = 8'hFF;
        bus.in_len   = 4'd8;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_dv_pre", 32'(bus.d_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_dv",   32'(bus.d_valid),   32'd0);
        check("mid_d",    32'(bus.d),         32'd0);
        check("mid_done", 32'(bus.done),      32'd0);
        check("mid_cnt",  32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        tick();
        check("post_rdy", 32'(bus.in_ready), 32'd1);
        check("post_dv",  32'(bus.d_valid),  32'd0);
        repeat (8) tick();
        check("post_cnt", 32'(bus.frame_cnt), 32'd0);
        check("post_done", 32'(bus.done),     32'd0);

        // Counter wrap: preload 0xFFFF while idle, then one more frame
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        tick();
        exp_cnt = 16'hFFFF;
        check("wrap_pre", 32'(bus.frame_cnt), 32'h0000_FFFF);
        run_frame(8'b0000_0010, 4'd2, "wrap");
        check("wrap_zero", 32'(bus.frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_gen

`default_nettype wire
